// File: rtl/ex_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// ex_muldiv_ctrl
//   Multi-cycle multiply/divide sequencer that sits beside the EX-stage ALU.
//   Accepts MULT/MULTU/DIV/DIVU, iterates one bit per cycle on operand
//   magnitudes (shift-add multiply, restoring divide), applies sign
//   correction in a FIXUP cycle and commits the 64-bit result to HI/LO.
//
//   Ports
//     clock   : system clock, all state changes on the rising edge
//     reset   : synchronous, active-high reset (dominates flush and start)
//     start   : issue request (op/srcA/srcB valid)
//     op      : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     srcA    : multiplicand / dividend
//     srcB    : multiplier / divisor
//     flush   : abort an op that is still iterating
//     rdHiLo  : MFHI/MFLO present in ID/EX this cycle
//     busy    : op in flight, including the cycle in which done is high
//     stall   : pipeline hold request (combinational)
//     done    : one-cycle pulse in the cycle HI/LO first show a new result
//     hi, lo  : HI (remainder / upper product), LO (quotient / lower product)
//
//   Build option
//     MULDIV_EARLY_OUT_EN : when defined, multiplies leave the iteration
//     phase as soon as the remaining multiplier magnitude bits are all zero.
// ---------------------------------------------------------------------------
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    input  logic             rdHiLo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    localparam logic [1:0]         OP_MULT  = 2'b00;
    localparam logic [1:0]         OP_DIV   = 2'b10;
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST = {CNT_W{1'b1}};

    // Two's-complement negate of a WIDTH-bit value when neg is set.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Two's-complement negate of a 2*WIDTH-bit value when neg is set.
    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [1:0]         op_q,     op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   a_raw_q,  a_raw_d;   // unmodified dividend for divide-by-zero
    logic [2*WIDTH-1:0] acc_q,    acc_d;     // mult: product; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;   // mult: multiplicand shifted left each iteration
    logic [WIDTH-1:0]   b_q,      b_d;       // mult: multiplier shifted right; div: divisor
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;

    logic               is_signed_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    // Operand magnitudes, one divide trial step and the sign-corrected results.
    always_comb begin
        is_signed_s = ~op[0];
        a_mag_s     = cond_neg_w(srcA, is_signed_s & srcA[WIDTH-1]);
        b_mag_s     = cond_neg_w(srcB, is_signed_s & srcB[WIDTH-1]);
        // Partial remainder shifted left by one with the next dividend bit;
        // the MSB of the difference is the borrow (trial failed).
        rem_sh_s    = acc_q[2*WIDTH-1:WIDTH-1];
        diff_s      = rem_sh_s - {1'b0, b_q};
        prod_fix_s  = cond_neg_2w(acc_q, (op_q == OP_MULT) & (sign_a_q ^ sign_b_q));
        quo_fix_s   = cond_neg_w(acc_q[WIDTH-1:0], (op_q == OP_DIV) & (sign_a_q ^ sign_b_q));
        rem_fix_s   = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], (op_q == OP_DIV) & sign_a_q);
    end

    // Next-state and datapath update for the IDLE / RUN / FIXUP sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_raw_d  = a_raw_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d  = S_RUN;
                    cnt_d    = CNT_ZERO;
                    op_d     = op;
                    sign_a_d = is_signed_s & srcA[WIDTH-1];
                    sign_b_d = is_signed_s & srcB[WIDTH-1];
                    a_raw_d  = srcA;
                    b_d      = b_mag_s;
                    if (op[1] == 1'b0) begin
                        acc_d   = ZERO_2W;
                        mcand_d = {ZERO_W, a_mag_s};
                    end else begin
                        acc_d   = {ZERO_W, a_mag_s};
                        mcand_d = ZERO_2W;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (op_q[1] == 1'b0) begin
                        if (b_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end else begin
                            acc_d = acc_q;
                        end
                        mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
                        b_d     = {1'b0, b_q[WIDTH-1:1]};
                    end else begin
                        if (!diff_s[WIDTH]) begin
                            acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                        end
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIXUP;
                    end else begin
                        state_d = S_RUN;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    // Bits still to be consumed after this iteration are all zero.
                    if ((op_q[1] == 1'b0) && (b_q[WIDTH-1:1] == {(WIDTH-1){1'b0}})) begin
                        state_d = S_FIXUP;
                    end else begin
                        state_d = state_d;
                    end
`else
                    state_d = state_d;
`endif
                end
            end

            S_FIXUP: begin
                // flush is deliberately ignored here: the result always commits.
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q[1] == 1'b0) begin
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end else if (b_q == ZERO_W) begin
                    hi_d = a_raw_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fix_s;
                    lo_d = quo_fix_s;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy covers the whole op including the cycle done is high.
        busy_d = (state_d != S_IDLE) | done_d;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            op_q     <= 2'b00;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_raw_q  <= ZERO_W;
            acc_q    <= ZERO_2W;
            mcand_q  <= ZERO_2W;
            b_q      <= ZERO_W;
            hi_q     <= ZERO_W;
            lo_q     <= ZERO_W;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_raw_q  <= a_raw_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // The done cycle is already IDLE, so a new op or an MFHI/MFLO there
    // proceeds without a stall and sees the freshly written HI/LO.
    assign stall = (state_q != S_IDLE) & (start | rdHiLo);
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
